boot_sram_arb: RTL and testbench



---
 rtl/boot_sram_arb_pkg.sv | 23 ++
 rtl/boot_sram_arb_rr_arb2.sv | 34 +++
 rtl/boot_sram_arb.sv | 120 ++++++++++++
 tb/tb_boot_sram_arb.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_sram_arb_pkg.sv
// Shared grant encoding and width helpers for the boot SRAM arbiter.
package boot_sram_arb_pkg;

  localparam int DATA_W_DFLT      = 32;
  localparam int SRAM_ADDR_W_DFLT = 15;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_BOOT = 2'd1;
  localparam logic [1:0] G_I    = 2'd2;
  localparam logic [1:0] G_D    = 2'd3;

  function automatic int word_addr_w(input int aw);
    return aw - 2;
  endfunction

  function automatic int byte_lanes(input int dw);
    return dw / 8;
  endfunction

  localparam int WORD_ADDR_W = word_addr_w(SRAM_ADDR_W_DFLT);
  localparam int LANES       = byte_lanes(DATA_W_DFLT);

endpackage

// File: rtl/boot_sram_arb_rr_arb2.sv
// Two-requester round-robin: on a tie the requester not served last wins.
// Requester 0 is the instruction bus, requester 1 the data bus.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  // last_q = 0: requester 0 served last, so requester 1 wins the first tie
  logic last_q;
  logic last_d;

  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
      if (|req_i) last_d = gnt_o[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b0;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/boot_sram_arb.sv
// Single-port SRAM arbiter: boot loader writes preempt everything, the CPU
// instruction and data buses share the remaining cycles round-robin.
module boot_sram_arb
  import boot_sram_arb_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DFLT,
  parameter int SRAM_ADDR_W = SRAM_ADDR_W_DFLT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     boot_valid,
  input  logic [SRAM_ADDR_W-1:0]   boot_addr,
  input  logic [DATA_W-1:0]        boot_wdata,
  input  logic [DATA_W/8-1:0]      boot_wstrb,
  input  logic                     i_valid,
  input  logic [SRAM_ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]        i_rdata,
  output logic                     i_ready,
  input  logic                     d_valid,
  input  logic [SRAM_ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]        d_wdata,
  input  logic [DATA_W/8-1:0]      d_wstrb,
  output logic [DATA_W-1:0]        d_rdata,
  output logic                     d_ready,
  output logic                     mem_en,
  output logic [DATA_W/8-1:0]      mem_we,
  output logic [SRAM_ADDR_W-3:0]   mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     boot_conflict
);

  logic [1:0]        sel;
  logic [1:0]        cpu_req;
  logic [1:0]        cpu_gnt;
  logic              i_rdy_q, i_rdy_d;
  logic              d_rdy_q, d_rdy_d;
  logic              conflict_q, conflict_d;
  logic [DATA_W-1:0] i_hold_q, i_hold_d;
  logic [DATA_W-1:0] d_hold_q, d_hold_d;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^{boot_addr[1:0], i_addr[1:0], d_addr[1:0]};

  // A master sitting in its ready cycle cannot be re-granted back to back
  assign cpu_req = {d_valid & ~d_rdy_q, i_valid & ~i_rdy_q};

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst   (rst),
    .req_i (cpu_req),
    .en_i  (~boot_valid),
    .gnt_o (cpu_gnt)
  );

  always_comb begin
    sel = G_NONE;
    if (boot_valid)      sel = G_BOOT;
    else if (cpu_gnt[0]) sel = G_I;
    else if (cpu_gnt[1]) sel = G_D;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (sel)
      G_BOOT: begin
        mem_en    = 1'b1;
        mem_we    = boot_wstrb;
        mem_addr  = boot_addr[SRAM_ADDR_W-1:2];
        mem_wdata = boot_wdata;
      end
      G_I: begin
        mem_en    = 1'b1;
        mem_addr  = i_addr[SRAM_ADDR_W-1:2];
      end
      G_D: begin
        mem_en    = 1'b1;
        mem_we    = d_wstrb;
        mem_addr  = d_addr[SRAM_ADDR_W-1:2];
        mem_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    i_rdy_d    = (sel == G_I);
    d_rdy_d    = (sel == G_D);
    i_hold_d   = i_rdy_q ? mem_rdata : i_hold_q;
    d_hold_d   = d_rdy_q ? mem_rdata : d_hold_q;
    conflict_d = conflict_q | (boot_valid & (i_valid | d_valid));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_rdy_q    <= 1'b0;
      d_rdy_q    <= 1'b0;
      i_hold_q   <= '0;
      d_hold_q   <= '0;
      conflict_q <= 1'b0;
    end else begin
      i_rdy_q    <= i_rdy_d;
      d_rdy_q    <= d_rdy_d;
      i_hold_q   <= i_hold_d;
      d_hold_q   <= d_hold_d;
      conflict_q <= conflict_d;
    end
  end

  // Ready-cycle data comes straight from the SRAM; the hold register covers the rest
  assign i_ready       = i_rdy_q;
  assign d_ready       = d_rdy_q;
  assign i_rdata       = i_rdy_q ? mem_rdata : i_hold_q;
  assign d_rdata       = d_rdy_q ? mem_rdata : d_hold_q;
  assign boot_conflict = conflict_q;

endmodule

// File: tb/tb_boot_sram_arb.sv
// Bench for boot_sram_arb: directed scenarios followed by random traffic, all
// checked against a cycle-level reference model with its own shadow memory.
module tb_boot_sram_arb;
  import boot_sram_arb_pkg::*;

  localparam int NW = 1 << WORD_ADDR_W;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   boot_valid;
  logic [14:0]            boot_addr;
  logic [31:0]            boot_wdata;
  logic [LANES-1:0]       boot_wstrb;
  logic                   i_valid;
  logic [14:0]            i_addr;
  logic [31:0]            i_rdata;
  logic                   i_ready;
  logic                   d_valid;
  logic [14:0]            d_addr;
  logic [31:0]            d_wdata;
  logic [LANES-1:0]       d_wstrb;
  logic [31:0]            d_rdata;
  logic                   d_ready;
  logic                   mem_en;
  logic [LANES-1:0]       mem_we;
  logic [WORD_ADDR_W-1:0] mem_addr;
  logic [31:0]            mem_wdata;
  logic [31:0]            mem_rdata;
  logic                   boot_conflict;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  boot_sram_arb dut (
    .clk(clk), .rst(rst),
    .boot_valid(boot_valid), .boot_addr(boot_addr), .boot_wdata(boot_wdata), .boot_wstrb(boot_wstrb),
    .i_valid(i_valid), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .boot_conflict(boot_conflict)
  );

  function automatic logic [31:0] init_word(input int w);
    if (w == 4) return 32'hDEADBEEF;
    if (w == 8) return 32'hCAFEF00D;
    return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // SRAM: byte-write, one-cycle read latency, read returns the pre-write word
  logic [31:0] sram [0:NW-1];
  bit          init_done;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int w = 0; w < NW; w++) sram[w] <= init_word(w);
      init_done <= 1'b1;
    end else if (mem_en) begin
      for (int b = 0; b < LANES; b++)
        if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= sram[mem_addr];
    end
  end

  // Reference model state
  logic [31:0] shadow [0:NW-1];
  logic        m_ird, m_drd, m_last_i, m_conf, m_dwr, m_dhold_ok;
  logic [31:0] m_iexp, m_dexp, m_ihold, m_dhold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ird = 1'b0; m_drd = 1'b0; m_last_i = 1'b1; m_conf = 1'b0;
    m_ihold = '0; m_dhold = '0; m_dhold_ok = 1'b1; m_dwr = 1'b0;
  endtask

  task automatic shadow_write(input int a, input logic [3:0] we, input logic [31:0] wd);
    for (int b = 0; b < LANES; b++)
      if (we[b]) shadow[a][8*b +: 8] = wd[8*b +: 8];
  endtask

  // One clock cycle: compare outputs against the model, advance the model, clock.
  task automatic step();
    logic ie, de;
    int   who;  // 0 none, 1 boot, 2 instr, 3 data
    int   a;
    #1;
    ie = i_valid && !m_ird;
    de = d_valid && !m_drd;
    if (boot_valid)  who = 1;
    else if (ie && de) who = m_last_i ? 3 : 2;
    else if (ie)     who = 2;
    else if (de)     who = 3;
    else             who = 0;
    a = (who == 1) ? int'(boot_addr >> 2) : (who == 2) ? int'(i_addr >> 2) : int'(d_addr >> 2);

    chk("mem_en", mem_en, (who != 0));
    chk("mem_we", mem_we, (who == 1) ? boot_wstrb : (who == 3) ? d_wstrb : 4'h0);
    if (who != 0) chk("mem_addr", mem_addr, a);
    if (who == 1) chk("mem_wdata_boot", mem_wdata, boot_wdata);
    if (who == 3 && d_wstrb != 0) chk("mem_wdata_d", mem_wdata, d_wdata);
    chk("i_ready", i_ready, m_ird);
    chk("d_ready", d_ready, m_drd);
    chk("i_rdata", i_rdata, m_ird ? m_iexp : m_ihold);
    if (m_drd && !m_dwr)          chk("d_rdata_ready", d_rdata, m_dexp);
    else if (!m_drd && m_dhold_ok) chk("d_rdata_hold", d_rdata, m_dhold);
    chk("boot_conflict", boot_conflict, m_conf);

    if (m_ird) m_ihold = m_iexp;
    if (m_drd) begin
      m_dhold_ok = !m_dwr;
      if (!m_dwr) m_dhold = m_dexp;
    end
    if (who == 1) shadow_write(a, boot_wstrb, boot_wdata);
    if (who == 2) m_iexp = shadow[a];
    if (who == 3) begin
      m_dexp = shadow[a];
      m_dwr  = (d_wstrb != 0);
      shadow_write(a, d_wstrb, d_wdata);
    end
    m_ird = (who == 2);
    m_drd = (who == 3);
    if (who >= 2) m_last_i = (who == 2);
    m_conf = m_conf | (boot_valid & (i_valid | d_valid));
    if (rst) model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    boot_valid = 1'b0; boot_addr = '0; boot_wdata = '0; boot_wstrb = '0;
    i_valid = 1'b0; i_addr = '0;
    d_valid = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
  endtask

  initial begin
    int boot_left;
    for (int w = 0; w < NW; w++) shadow[w] = init_word(w);
    model_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    #1;
    chk("reset_mem_en", mem_en, 1'b0);
    chk("reset_i_rdata", i_rdata, 32'h0);
    step();

    // Boot burst
    for (int k = 0; k < 4; k++) begin
      boot_valid = 1'b1; boot_addr = 15'h7000 + 15'(4*k);
      boot_wdata = 32'hA0 + 32'(k); boot_wstrb = 4'hF;
      #1;
      chk("boot_addr", mem_addr, 32'h1C00 + 32'(k));
      chk("boot_we", mem_we, 4'hF);
      step();
      chk("boot_no_iready", i_ready, 1'b0);
      chk("boot_no_dready", d_ready, 1'b0);
    end
    idle();

    // Instruction read of word 4
    i_valid = 1'b1; i_addr = 15'h0010;
    #1;
    chk("iread_en", mem_en, 1'b1);
    chk("iread_addr", mem_addr, 32'h4);
    step();
    chk("iread_ready", i_ready, 1'b1);
    chk("iread_data", i_rdata, 32'hDEADBEEF);
    i_valid = 1'b0;
    step();
    chk("iread_hold", i_rdata, 32'hDEADBEEF);
    chk("iread_ready_off", i_ready, 1'b0);

    // Contention from reset: D,I,D,I...
    rst = 1'b1; step(); rst = 1'b0;
    i_valid = 1'b1; i_addr = 15'h0100;
    d_valid = 1'b1; d_addr = 15'h0200; d_wstrb = 4'h0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("cont_en", mem_en, 1'b1);
      chk("cont_addr", mem_addr, (k % 2 == 0) ? 32'h80 : 32'h40);
      step();
    end
    idle();
    step();

    // Partial data write to word 8, then read it back
    d_valid = 1'b1; d_addr = 15'h0020; d_wdata = 32'h12345678; d_wstrb = 4'h3;
    #1;
    chk("dwr_we", mem_we, 4'h3);
    chk("dwr_addr", mem_addr, 32'h8);
    step();
    chk("dwr_ready", d_ready, 1'b1);
    d_wstrb = 4'h0;
    step();
    step();
    chk("drd_ready", d_ready, 1'b1);
    chk("drd_data", d_rdata, 32'hCAFE5678);
    idle();
    step();

    // Boot preempts a pending data read
    d_valid = 1'b1; d_addr = 15'h0040; d_wstrb = 4'h0;
    for (int k = 0; k < 3; k++) begin
      boot_valid = 1'b1; boot_addr = 15'h0400 + 15'(4*k);
      boot_wdata = 32'h55AA0000 + 32'(k); boot_wstrb = 4'hF;
      step();
      chk("pre_no_dready", d_ready, 1'b0);
    end
    boot_valid = 1'b0;
    chk("pre_conflict", boot_conflict, 1'b1);
    #1;
    chk("pre_d_grant", mem_addr, 32'h10);
    step();
    chk("pre_dready", d_ready, 1'b1);
    idle();
    step();

    // Reset during an instruction ready cycle
    i_valid = 1'b1; i_addr = 15'h0010;
    step();
    chk("rmid_ready", i_ready, 1'b1);
    rst = 1'b1; i_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("rmid_squash", i_ready, 1'b0);
    chk("rmid_rdata", i_rdata, 32'h0);
    chk("rmid_conflict", boot_conflict, 1'b0);
    step();

    // Random traffic
    boot_left = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      if (!i_valid || i_ready) begin
        i_valid = ($urandom_range(0, 3) != 0);
        i_addr  = 15'($urandom_range(0, 255));
      end
      if (!d_valid || d_ready) begin
        d_valid = ($urandom_range(0, 3) != 0);
        d_addr  = 15'($urandom_range(0, 255));
        d_wdata = $urandom;
        d_wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      end
      if (boot_left == 0 && $urandom_range(0, 15) == 0) boot_left = $urandom_range(1, 4);
      if (boot_left > 0) begin
        boot_valid = 1'b1;
        boot_addr  = 15'($urandom_range(0, 255));
        boot_wdata = $urandom;
        boot_wstrb = 4'($urandom_range(0, 15));
        boot_left--;
      end else begin
        boot_valid = 1'b0;
      end
      step();
    end
    rst = 1'b0;
    idle();
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
